// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared types for the serial magnitude comparator: FSM state encoding and
// a sizing helper for the slice index register.
package serial_magnitude_comparator_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Index register width; a single-slice configuration still needs one bit.
    function automatic int idx_w(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/digit_comparator.sv
// Combinational compare of one DIGIT-bit slice; unsigned, lt is implied by !eq && !gt.
module digit_comparator #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             eq,
    output logic             gt
);

    assign eq = (a == b);
    assign gt = (a > b);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks the operands DIGIT bits at a time from
// the MSB slice and stops at the first slice that differs.
module serial_magnitude_comparator
    import serial_magnitude_comparator_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGIT  = 1,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int IW   = idx_w(NDIG);
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    localparam logic [WIDTH-1:0] SIGN_FLIP =
        (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("serial_magnitude_comparator: WIDTH must be 2..32");
    end
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("serial_magnitude_comparator: WIDTH must be a multiple of DIGIT");
    end

    state_t            state, state_nxt;
    logic [IW-1:0]     idx, idx_nxt;
    logic [WIDTH-1:0]  a_q, b_q, a_nxt, b_nxt;
    logic              busy_nxt, done_nxt, eq_nxt, gt_nxt, lt_nxt;

    logic [NDIG-1:0][DIGIT-1:0] a_dv, b_dv;
    logic                       dig_eq, dig_gt;

    assign a_dv = a_q;
    assign b_dv = b_q;

    digit_comparator #(.DIGIT(DIGIT)) u_digit (
        .a  (a_dv[idx]),
        .b  (b_dv[idx]),
        .eq (dig_eq),
        .gt (dig_gt)
    );

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        a_nxt     = a_q;
        b_nxt     = b_q;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        eq_nxt    = eq;
        gt_nxt    = gt;
        lt_nxt    = lt;
        case (state)
            IDLE: begin
                if (start) begin
                    a_nxt     = a ^ SIGN_FLIP;
                    b_nxt     = b ^ SIGN_FLIP;
                    idx_nxt   = IW'(NDIG - 1);
                    eq_nxt    = 1'b0;
                    gt_nxt    = 1'b0;
                    lt_nxt    = 1'b0;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (!dig_eq) begin
                    gt_nxt    = dig_gt;
                    lt_nxt    = !dig_gt;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (idx == '0) begin
                    eq_nxt    = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    // busy only rises for cycles that will examine another slice
                    idx_nxt  = idx - 1'b1;
                    busy_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx  <= '0;
            a_q  <= '0;
            b_q  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            eq   <= 1'b0;
            gt   <= 1'b0;
            lt   <= 1'b0;
        end else begin
            idx  <= idx_nxt;
            a_q  <= a_nxt;
            b_q  <= b_nxt;
            busy <= busy_nxt;
            done <= done_nxt;
            eq   <= eq_nxt;
            gt   <= gt_nxt;
            lt   <= lt_nxt;
        end
    end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for serial_magnitude_comparator: three configurations (8/1/unsigned,
// 8/1/signed, 16/4/unsigned) checked against an arithmetic reference model.
module tb_serial_magnitude_comparator;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] start_v = '0;
    logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [15:0] a2 = '0, b2 = '0;
    wire  [2:0] busy_w, done_w, eq_w, gt_w, lt_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_magnitude_comparator #(.WIDTH(8), .DIGIT(1), .SIGNED(0)) u_d0 (
        .clk(clk), .reset_n(reset_n), .start(start_v[0]), .a(a0), .b(b0),
        .busy(busy_w[0]), .done(done_w[0]), .eq(eq_w[0]), .gt(gt_w[0]), .lt(lt_w[0]));
    serial_magnitude_comparator #(.WIDTH(8), .DIGIT(1), .SIGNED(1)) u_d1 (
        .clk(clk), .reset_n(reset_n), .start(start_v[1]), .a(a1), .b(b1),
        .busy(busy_w[1]), .done(done_w[1]), .eq(eq_w[1]), .gt(gt_w[1]), .lt(lt_w[1]));
    serial_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .SIGNED(0)) u_d2 (
        .clk(clk), .reset_n(reset_n), .start(start_v[2]), .a(a2), .b(b2),
        .busy(busy_w[2]), .done(done_w[2]), .eq(eq_w[2]), .gt(gt_w[2]), .lt(lt_w[2]));

    function automatic int w_of(input int sel);
        return (sel == 2) ? 16 : 8;
    endfunction

    function automatic int d_of(input int sel);
        return (sel == 2) ? 4 : 1;
    endfunction

    function automatic bit s_of(input int sel);
        return (sel == 1);
    endfunction

    function automatic longint raw(input int sel, input logic [15:0] v);
        return longint'(v) & ((longint'(1) << w_of(sel)) - 1);
    endfunction

    // Numeric value of an operand as the configuration interprets it.
    function automatic longint val(input int sel, input logic [15:0] v);
        longint x = raw(sel, v);
        if (s_of(sel) && x >= (longint'(1) << (w_of(sel) - 1)))
            x -= (longint'(1) << w_of(sel));
        return x;
    endfunction

    // Expected {eq,gt,lt}.
    function automatic logic [2:0] ref_res(input int sel, input logic [15:0] av, input logic [15:0] bv);
        longint x = val(sel, av);
        longint y = val(sel, bv);
        if (x == y) return 3'b100;
        if (x > y)  return 3'b010;
        return 3'b001;
    endfunction

    // Slices examined: position of the most significant differing slice.
    function automatic int ref_k(input int sel, input logic [15:0] av, input logic [15:0] bv);
        int     d    = d_of(sel);
        int     ndig = w_of(sel) / d;
        longint x    = raw(sel, av);
        longint y    = raw(sel, bv);
        longint m    = (longint'(1) << d) - 1;
        for (int j = ndig - 1; j >= 0; j--)
            if (((x >> (j * d)) & m) != ((y >> (j * d)) & m)) return ndig - j;
        return ndig;
    endfunction

    task automatic drive(input int sel, input logic [15:0] av, input logic [15:0] bv, input logic st);
        case (sel)
            0: begin a0 = av[7:0]; b0 = bv[7:0]; end
            1: begin a1 = av[7:0]; b1 = bv[7:0]; end
            default: begin a2 = av; b2 = bv; end
        endcase
        start_v[sel] = st;
    endtask

    // Caller sits at a negedge. Operands are scrambled every cycle after
    // acceptance; glitch>0 re-pulses start after that many edges.
    task automatic run_cmp(input int sel, input logic [15:0] av, input logic [15:0] bv,
                           input bit chk_hold, input int glitch, input string name);
        int         k     = ref_k(sel, av, bv);
        logic [2:0] r     = ref_res(sel, av, bv);
        int         edges = 0;
        int         bcnt  = 0;
        bit         fin   = 0;
        logic [2:0] got;
        drive(sel, av, bv, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(sel, 16'($urandom), 16'($urandom), 1'b0);
        while (!fin && edges <= k + 3) begin
            if (done_w[sel]) begin
                fin = 1;
            end else begin
                if (busy_w[sel]) bcnt++;
                @(posedge clk);
                edges++;
                @(negedge clk);
                drive(sel, 16'($urandom), 16'($urandom), (glitch != 0 && edges == glitch));
            end
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL %s timeout: no done after %0d edges, required %0d", name, edges, k);
            return;
        end
        got = {eq_w[sel], gt_w[sel], lt_w[sel]};
        checks++;
        if (edges !== k) begin
            errors++;
            $display("FAIL %s latency: got %0d edges, required %0d", name, edges, k);
        end
        checks++;
        if (bcnt !== k - 1) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d, required %0d", name, bcnt, k - 1);
        end
        checks++;
        if (busy_w[sel] !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_at_done: got %b, required 0", name, busy_w[sel]);
        end
        checks++;
        if (got !== r) begin
            errors++;
            $display("FAIL %s result eq/gt/lt: got %b, required %b", name, got, r);
        end
        if (chk_hold) begin
            @(posedge clk);
            @(negedge clk);
            got = {eq_w[sel], gt_w[sel], lt_w[sel]};
            checks++;
            if (done_w[sel] !== 1'b0 || busy_w[sel] !== 1'b0 || got !== r) begin
                errors++;
                $display("FAIL %s hold: got done=%b busy=%b res=%b, required done=0 busy=0 res=%b",
                         name, done_w[sel], busy_w[sel], got, r);
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy_w, done_w, eq_w, gt_w, lt_w} !== 15'b0) begin
            errors++;
            $display("FAIL reset_state: got %b, required all 0", {busy_w, done_w, eq_w, gt_w, lt_w});
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed;
        run_cmp(0, 16'h00A5, 16'h00A5, 1, 0, "eq_a5");
        run_cmp(0, 16'h0080, 16'h007F, 1, 0, "gt_early");
        run_cmp(1, 16'h0080, 16'h0001, 1, 0, "signed_lt");
        run_cmp(1, 16'h00FF, 16'h00FE, 1, 0, "signed_gt");
        run_cmp(2, 16'h1234, 16'h1243, 1, 0, "w16_lt");
        run_cmp(0, 16'h0000, 16'h0001, 1, 0, "lsb_lt");
        run_cmp(2, 16'hFFFF, 16'hFFFF, 1, 0, "w16_eq");
    endtask

    task automatic test_random;
        for (int sel = 0; sel < 3; sel++) begin
            for (int n = 0; n < 12; n++) begin
                logic [15:0] av = 16'($urandom);
                logic [15:0] bv;
                int          g  = 0;
                case ($urandom_range(0, 2))
                    0:       bv = av;
                    1:       bv = av ^ (16'h1 << $urandom_range(0, w_of(sel) - 1));
                    default: bv = 16'($urandom);
                endcase
                if ($urandom_range(0, 2) == 0 && ref_k(sel, av, bv) > 1)
                    g = $urandom_range(1, ref_k(sel, av, bv) - 1);
                run_cmp(sel, av, bv, ($urandom_range(0, 1) == 1), g, "random");
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_start_ignored;
        run_cmp(0, 16'h0055, 16'h0055, 1, 3, "start_ignored_eq");
        run_cmp(2, 16'h8001, 16'h8000, 1, 2, "start_ignored_w16");
    endtask

    task automatic test_back_to_back;
        run_cmp(0, 16'h003C, 16'h003C, 0, 0, "b2b_first");
        run_cmp(0, 16'h0010, 16'h0020, 0, 0, "b2b_second");
        run_cmp(0, 16'h0081, 16'h0080, 1, 0, "b2b_third");
    endtask

    task automatic test_reset_mid;
        bit saw_done = 0;
        drive(0, 16'h0000, 16'h0000, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(0, 16'h0000, 16'h0000, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy_w, done_w, eq_w, gt_w, lt_w} !== 15'b0) begin
            errors++;
            $display("FAIL reset_mid outputs: got %b, required all 0", {busy_w, done_w, eq_w, gt_w, lt_w});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done_w[0] || busy_w[0]) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL reset_mid aborted: got done/busy activity after release, required none");
        end
        run_cmp(0, 16'h0012, 16'h0034, 1, 0, "after_reset");
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_start_ignored;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
